// File: rtl/l2_cache_nway_pkg.sv
// Shared types for the N-way L2 cache: FSM state encoding, latched request, address helper.
package l2_cache_nway_pkg;

  typedef logic [2:0] l2_state_t;

  localparam l2_state_t ST_IDLE  = 3'd0;
  localparam l2_state_t ST_READ  = 3'd1;
  localparam l2_state_t ST_CHECK = 3'd2;
  localparam l2_state_t ST_WB    = 3'd3;
  localparam l2_state_t ST_FILL  = 3'd4;

  // Request captured in IDLE; a simultaneous read+write is recorded as a write.
  typedef struct packed {
    logic [31:0] addr;
    logic        is_write;
  } l2_req_t;

  // Clear the byte-offset bits of an address.
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned off_bits);
    return addr & ~((32'd1 << off_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/l2_cache_nway_plru_tree.sv
// Tree pseudo-LRU: victim lookup and post-access update for one set.
module l2_plru_tree #(
  parameter int unsigned NUM_WAYS = 4
) (
  input  logic [NUM_WAYS-2:0]         plru_i,
  input  logic [$clog2(NUM_WAYS)-1:0] access_way_i,
  output logic [$clog2(NUM_WAYS)-1:0] victim_o,
  output logic [NUM_WAYS-2:0]         plru_next_o
);

  localparam int unsigned LOG_WAYS = $clog2(NUM_WAYS);

  // Follow the node bits from the root; 0 steps left, 1 steps right.
  always_comb begin : victim_walk
    logic [LOG_WAYS-1:0] node;
    logic                b;
    node     = '0;
    victim_o = '0;
    for (int l = 0; l < LOG_WAYS; l++) begin
      b = plru_i[node];
      victim_o[LOG_WAYS-1-l] = b;
      node = LOG_WAYS'({node, 1'b1} + {{LOG_WAYS{1'b0}}, b});
    end
  end

  // Point every node on the accessed way's path away from it.
  always_comb begin : update_walk
    logic [LOG_WAYS-1:0] node;
    logic                d;
    node        = '0;
    plru_next_o = plru_i;
    for (int l = 0; l < LOG_WAYS; l++) begin
      d = access_way_i[LOG_WAYS-1-l];
      plru_next_o[node] = ~d;
      node = LOG_WAYS'({node, 1'b1} + {{LOG_WAYS{1'b0}}, d});
    end
  end

endmodule

// File: rtl/l2_cache_nway.sv
// N-way set-associative write-back/write-allocate L2 with integrated controller.
module l2_cache_nway
  import l2_cache_nway_pkg::*;
#(
  parameter int unsigned S_OFFSET = 5,
  parameter int unsigned S_INDEX  = 4,
  parameter int unsigned NUM_WAYS = 4,
  parameter int unsigned S_TAG    = 32 - S_OFFSET - S_INDEX,
  parameter int unsigned S_MASK   = 2**S_OFFSET,
  parameter int unsigned S_LINE   = 8*S_MASK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       mem_address,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [S_LINE-1:0] mem_wdata256,
  input  logic [S_MASK-1:0] mem_byte_enable256,
  output logic [S_LINE-1:0] mem_rdata256,
  output logic              mem_resp,
  output logic [31:0]       pmem_address,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [S_LINE-1:0] pmem_wdata,
  input  logic [S_LINE-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int unsigned NUM_SETS = 2**S_INDEX;
  localparam int unsigned LOG_WAYS = $clog2(NUM_WAYS);

  l2_state_t                               state_q, state_d;
  l2_req_t                                 req_q, req_d;
  logic [S_LINE-1:0]                       wdata_q, wdata_d;
  logic [S_MASK-1:0]                       mask_q, mask_d;
  logic [LOG_WAYS-1:0]                     victim_q, victim_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]       valid_q, valid_d;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]       dirty_q, dirty_d;
  logic [NUM_SETS-1:0][NUM_WAYS-2:0]       plru_q, plru_d;

  logic [S_TAG-1:0]    req_tag;
  logic [S_INDEX-1:0]  req_idx;
  logic [S_LINE-1:0]   data_rd [NUM_WAYS];
  logic [S_TAG-1:0]    tag_rd  [NUM_WAYS];
  logic [NUM_WAYS-1:0] data_we, tag_we;
  logic [S_MASK-1:0]   arr_be;
  logic [S_LINE-1:0]   arr_wdata;
  logic                hit_any, inv_any;
  logic [LOG_WAYS-1:0] hit_way, inv_way, plru_victim, plru_access, victim_sel;
  logic [NUM_WAYS-2:0] plru_next;

  assign req_tag = req_q.addr[31 -: S_TAG];
  assign req_idx = req_q.addr[S_OFFSET +: S_INDEX];

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic [S_LINE-1:0] data_mem [NUM_SETS];
    logic [S_TAG-1:0]  tag_mem  [NUM_SETS];

    // Per-way data/tag storage: byte-masked write, one-cycle registered read at the latched index.
    always_ff @(posedge clk) begin
      if (data_we[w]) begin
        for (int b = 0; b < int'(S_MASK); b++) begin
          if (arr_be[b]) data_mem[req_idx][8*b +: 8] <= arr_wdata[8*b +: 8];
        end
      end
      if (tag_we[w]) tag_mem[req_idx] <= req_tag;
      data_rd[w] <= data_mem[req_idx];
      tag_rd[w]  <= tag_mem[req_idx];
    end
  end

  l2_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
    .plru_i       (plru_q[req_idx]),
    .access_way_i (plru_access),
    .victim_o     (plru_victim),
    .plru_next_o  (plru_next)
  );

  // Lowest-index hit way and lowest-index invalid way of the addressed set.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = int'(NUM_WAYS) - 1; w >= 0; w--) begin
      if (valid_q[req_idx][w] && (tag_rd[w] == req_tag)) begin
        hit_any = 1'b1;
        hit_way = LOG_WAYS'(w);
      end
      if (!valid_q[req_idx][w]) begin
        inv_any = 1'b1;
        inv_way = LOG_WAYS'(w);
      end
    end
  end

  // Controller next-state, array writes and port outputs.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    wdata_d      = wdata_q;
    mask_d       = mask_q;
    victim_d     = victim_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    plru_d       = plru_q;
    data_we      = '0;
    tag_we       = '0;
    arr_be       = mask_q;
    arr_wdata    = wdata_q;
    plru_access  = hit_way;
    victim_sel   = inv_any ? inv_way : plru_victim;
    mem_resp     = 1'b0;
    mem_rdata256 = data_rd[hit_way];
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = line_base(req_q.addr, S_OFFSET);
    pmem_wdata   = data_rd[victim_q];
    case (state_q)
      ST_IDLE: begin
        if (mem_read || mem_write) begin
          req_d.addr     = mem_address;
          req_d.is_write = mem_write;
          wdata_d        = mem_wdata256;
          mask_d         = mem_byte_enable256;
          state_d        = ST_READ;
        end
      end
      ST_READ: state_d = ST_CHECK;
      ST_CHECK: begin
        if (hit_any) begin
          mem_resp        = 1'b1;
          plru_d[req_idx] = plru_next;
          if (req_q.is_write) begin
            data_we[hit_way]          = 1'b1;
            dirty_d[req_idx][hit_way] = 1'b1;
          end
          state_d = ST_IDLE;
        end else begin
          victim_d = victim_sel;
          if (valid_q[req_idx][victim_sel] && dirty_q[req_idx][victim_sel]) state_d = ST_WB;
          else                                                              state_d = ST_FILL;
        end
      end
      ST_WB: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_rd[victim_q], req_idx, {S_OFFSET{1'b0}}};
        if (pmem_resp) state_d = ST_FILL;
      end
      ST_FILL: begin
        pmem_read   = 1'b1;
        plru_access = victim_q;
        if (pmem_resp) begin
          data_we[victim_q]          = 1'b1;
          tag_we[victim_q]           = 1'b1;
          arr_be                     = '1;
          arr_wdata                  = pmem_rdata;
          valid_d[req_idx][victim_q] = 1'b1;
          dirty_d[req_idx][victim_q] = 1'b0;
          plru_d[req_idx]            = plru_next;
          state_d                    = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controller and metadata registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      victim_q <= '0;
      valid_q  <= '0;
      dirty_q  <= '0;
      plru_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      victim_q <= victim_d;
      valid_q  <= valid_d;
      dirty_q  <= dirty_d;
      plru_q   <= plru_d;
    end
  end

endmodule

// File: tb/tb_l2_cache_nway.sv
// Directed bench for l2_cache_nway: a 4-way/16-set instance and an 8-way/4-set instance share stimulus.
module tb_l2_cache_nway;
  import l2_cache_nway_pkg::*;

  logic         clk;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read, mem_write;
  logic [255:0] mem_wdata256;
  logic [31:0]  mem_byte_enable256;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  logic [255:0] d4_rdata, d8_rdata, d4_pwdata, d8_pwdata;
  logic [31:0]  d4_paddr, d8_paddr;
  logic         d4_resp, d8_resp, d4_pread, d8_pread, d4_pwrite, d8_pwrite;

  logic         sel;
  logic [255:0] s_rdata, s_pwdata;
  logic [31:0]  s_paddr;
  logic         s_resp, s_pread, s_pwrite;

  int           n_assert = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  int           resp_cyc = 0;
  int           fill_cyc = 0;
  int           resp_lat = 2;
  int           lat_cnt  = 0;
  logic [7:0]   fill_pat = 8'h00;
  bit           both_seen = 1'b0;
  bit           ev_wr    [$];
  logic [31:0]  ev_addr  [$];
  logic [255:0] ev_wdata [$];

  l2_cache_nway dut4 (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata256(mem_wdata256), .mem_byte_enable256(mem_byte_enable256), .mem_rdata256(d4_rdata),
    .mem_resp(d4_resp), .pmem_address(d4_paddr), .pmem_read(d4_pread), .pmem_write(d4_pwrite),
    .pmem_wdata(d4_pwdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  l2_cache_nway #(.NUM_WAYS(8), .S_INDEX(2)) dut8 (
    .clk(clk), .rst(rst), .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata256(mem_wdata256), .mem_byte_enable256(mem_byte_enable256), .mem_rdata256(d8_rdata),
    .mem_resp(d8_resp), .pmem_address(d8_paddr), .pmem_read(d8_pread), .pmem_write(d8_pwrite),
    .pmem_wdata(d8_pwdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  assign s_rdata  = sel ? d8_rdata  : d4_rdata;
  assign s_resp   = sel ? d8_resp   : d4_resp;
  assign s_paddr  = sel ? d8_paddr  : d4_paddr;
  assign s_pread  = sel ? d8_pread  : d4_pread;
  assign s_pwrite = sel ? d8_pwrite : d4_pwrite;
  assign s_pwdata = sel ? d8_pwdata : d4_pwdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  // Memory model: logs each strobe's first cycle, answers after resp_lat cycles with the fill pattern.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (s_pread && s_pwrite) both_seen = 1'b1;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        lat_cnt   = 0;
      end else if (s_pread || s_pwrite) begin
        if (lat_cnt == 0) begin
          ev_wr.push_back(s_pwrite);
          ev_addr.push_back(s_paddr);
          ev_wdata.push_back(s_pwdata);
        end
        if (lat_cnt == resp_lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = {32{fill_pat}};
          if (s_pread) fill_cyc = cyc;
        end
        lat_cnt++;
      end else begin
        lat_cnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One request; lat counts edges from the IDLE cycle until mem_resp is seen.
  task automatic access(input bit w, input logic [31:0] a, input logic [255:0] d, input logic [31:0] m,
                        output logic [255:0] rd, output int lat);
    mem_address        = a;
    mem_read           = !w;
    mem_write          = w;
    mem_wdata256       = d;
    mem_byte_enable256 = m;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!s_resp && lat < 200);
    chk("mem_resp_seen", 256'(s_resp), 256'(1));
    resp_cyc  = cyc;
    rd        = s_rdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [255:0] rd;
  int           lat;
  int           n0;
  logic [31:0]  fill_addr [3] = '{32'h0000_2000, 32'h0000_3000, 32'h0000_4000};
  logic [7:0]   fill_byte [3] = '{8'hB1, 8'hC2, 8'hD3};
  // With tree PLRU, touching 2,0,1 leaves way 3 as the victim.
  logic [31:0]  touch_addr [3] = '{32'h0000_3000, 32'h0000_1000, 32'h0000_2000};

  initial begin
    sel = 1'b0; rst = 1'b1;
    mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_wdata256 = '0; mem_byte_enable256 = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_mem_resp",   256'(d4_resp),   256'(0));
    chk("rst_pmem_read",  256'(d4_pread),  256'(0));
    chk("rst_pmem_write", 256'(d4_pwrite), 256'(0));
    chk("rst_state",      256'(dut4.state_q), 256'(ST_IDLE));
    chk("rst_valid",      256'(dut4.valid_q), 256'(0));
    chk("rst_plru",       256'(dut4.plru_q),  256'(0));
    rst = 1'b0;

    // Clean miss: single fill at the line address, mem_resp two edges after the fill response.
    fill_pat = 8'hA5; n0 = ev_addr.size();
    access(1'b0, 32'h0000_1000, '0, '0, rd, lat);
    chk("miss_pmem_count", 256'(ev_addr.size() - n0), 256'(1));
    chk("miss_pmem_addr",  256'(ev_addr[n0]), 256'(32'h0000_1000));
    chk("miss_pmem_isrd",  256'(ev_wr[n0]), 256'(0));
    chk("miss_rdata",      rd, {32{8'hA5}});
    chk("miss_resp_delay", 256'(resp_cyc - fill_cyc), 256'(2));

    // Re-read hits in two cycles with no downstream traffic.
    n0 = ev_addr.size();
    access(1'b0, 32'h0000_1000, '0, '0, rd, lat);
    chk("hit_latency",     256'(lat), 256'(2));
    chk("hit_rdata",       rd, {32{8'hA5}});
    chk("hit_no_pmem",     256'(ev_addr.size() - n0), 256'(0));

    // Masked write hit merges the low four bytes and marks the line dirty.
    access(1'b1, 32'h0000_1000, 256'h1122_3344, 32'h0000_000F, rd, lat);
    chk("wr_hit_latency",  256'(lat), 256'(2));
    chk("wr_dirty",        256'(dut4.dirty_q[0][0]), 256'(1));
    access(1'b0, 32'h0000_1000, '0, '0, rd, lat);
    chk("wr_merge_rdata",  rd, {{28{8'hA5}}, 32'h1122_3344});

    // Fill ways 1..3 of set 0, dirty way 3, then touch 2,0,1.
    for (int i = 0; i < 3; i++) begin
      fill_pat = fill_byte[i]; n0 = ev_addr.size();
      access(1'b0, fill_addr[i], '0, '0, rd, lat);
      chk("set0_fill_addr", 256'(ev_addr[n0]), 256'(fill_addr[i]));
      chk("set0_fill_data", rd, {32{fill_byte[i]}});
    end
    access(1'b1, 32'h0000_4000, 256'hDEAD_BEEF, 32'h0000_000F, rd, lat);
    chk("way3_wr_latency", 256'(lat), 256'(2));
    for (int i = 0; i < 3; i++) begin
      access(1'b0, touch_addr[i], '0, '0, rd, lat);
      chk("touch_hit_latency", 256'(lat), 256'(2));
    end

    // Fifth tag: dirty way 3 written back (old tag address) before the fill; same-cycle responses.
    resp_lat = 0; fill_pat = 8'hE4; n0 = ev_addr.size();
    access(1'b0, 32'h0000_5000, '0, '0, rd, lat);
    chk("evict_pmem_count", 256'(ev_addr.size() - n0), 256'(2));
    chk("evict_wb_first",   256'(ev_wr[n0]), 256'(1));
    chk("evict_wb_addr",    256'(ev_addr[n0]), 256'(32'h0000_4000));
    chk("evict_wb_data",    ev_wdata[n0], {{28{8'hD3}}, 32'hDEAD_BEEF});
    chk("evict_fill_isrd",  256'(ev_wr[n0+1]), 256'(0));
    chk("evict_fill_addr",  256'(ev_addr[n0+1]), 256'(32'h0000_5000));
    chk("evict_rdata",      rd, {32{8'hE4}});
    access(1'b0, 32'h0000_1000, '0, '0, rd, lat);
    chk("way0_kept_latency", 256'(lat), 256'(2));
    chk("way0_kept_rdata",   rd, {{28{8'hA5}}, 32'h1122_3344});

    // Reset while FILL holds pmem_read: strobes drop, metadata clears, no mem_resp.
    resp_lat = 100000;
    mem_address = 32'h0000_6020; mem_read = 1'b1;
    for (int i = 0; i < 50 && !s_pread; i++) begin
      @(posedge clk); #1;
    end
    chk("rstfill_strobe", 256'(s_pread), 256'(1));
    mem_read = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    chk("rstfill_pmem_read", 256'(d4_pread),  256'(0));
    chk("rstfill_pmem_wr",   256'(d4_pwrite), 256'(0));
    chk("rstfill_mem_resp",  256'(d4_resp),   256'(0));
    chk("rstfill_valid",     256'(dut4.valid_q), 256'(0));
    rst = 1'b0; resp_lat = 2; fill_pat = 8'h77; n0 = ev_addr.size();
    access(1'b0, 32'h0000_1000, '0, '0, rd, lat);
    chk("post_rst_miss",  256'(ev_addr.size() - n0), 256'(1));
    chk("post_rst_addr",  256'(ev_addr[n0]), 256'(32'h0000_1000));
    chk("post_rst_rdata", rd, {32{8'h77}});

    // 8-way, 4 sets: eight misses fill ways 0..7 in order, the ninth evicts way 0.
    sel = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      fill_pat = 8'h10 + 8'(k);
      access(1'b0, 32'(k) * 32'h80, '0, '0, rd, lat);
      chk("w8_fill_rdata", rd, {32{fill_pat}});
      chk("w8_valid_order", 256'(dut8.valid_q[0]), 256'((1 << k) - 1));
    end
    fill_pat = 8'h19; n0 = ev_addr.size();
    access(1'b0, 32'h0000_0480, '0, '0, rd, lat);
    chk("w8_ninth_count", 256'(ev_addr.size() - n0), 256'(1));
    chk("w8_ninth_clean", 256'(ev_wr[n0]), 256'(0));
    access(1'b0, 32'h0000_0100, '0, '0, rd, lat);
    chk("w8_way1_hit",    256'(lat), 256'(2));
    chk("w8_way1_rdata",  rd, {32{8'h12}});
    n0 = ev_addr.size();
    access(1'b0, 32'h0000_0080, '0, '0, rd, lat);
    chk("w8_way0_evicted", 256'(ev_addr.size() - n0), 256'(1));

    chk("no_dual_strobe", 256'(both_seen), 256'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
